// File: rtl/motoro3_line_calc_param_seq_if.sv
// motoro3_line_calc_param_seq_if: request/result bundle between the register file and the line calculator
interface motoro3_line_calc_param_seq_if #(parameter int W = 12, parameter int NCH = 3);
  logic [W-1:0] m3r_pwmLenWant;
  logic [W-1:0] m3r_pwmMinMask;
  logic [4:0] lcStep;
  logic calc_start;
  logic calc_busy;
  logic calc_valid;
  logic [NCH*W-1:0] plLen;
  logic [NCH-1:0] plSign;
  logic [7:0] slLen;
  modport master (output m3r_pwmLenWant, m3r_pwmMinMask, lcStep, calc_start,
                  input calc_busy, calc_valid, plLen, plSign, slLen);
  modport slave (input m3r_pwmLenWant, m3r_pwmMinMask, lcStep, calc_start,
                 output calc_busy, calc_valid, plLen, plSign, slLen);
endinterface

// File: rtl/motoro3_line_calc_param_seq.sv
// motoro3_line_calc_param_seq: sequential multi-channel |sine| x want PWM length calculator with min floor
module motoro3_line_calc_param_seq #(
  parameter int W = 12,
  parameter int NCH = 3,
  parameter int PHASE_OFS = 8
) (
  input logic clk,
  input logic nRst,
  motoro3_line_calc_param_seq_if.slave bus
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, CLAMP, DONE} state_t;
  state_t r_st;
  logic [W-1:0] r_want, r_min;
  logic [4:0] r_step;
  logic [CW-1:0] r_ch;
  logic [2:0] r_bit;
  logic [7:0] r_mag;
  logic [W+7:0] r_acc;
  logic [W-1:0] r_sh [NCH];
  logic [NCH-1:0] r_sgn_sh;
  logic r_busy, r_valid;
  logic [NCH*W-1:0] r_len;
  logic [NCH-1:0] r_sgn;
  logic [7:0] r_sl;
  logic [4:0] w_step, w_idx;
  logic [6:0] w_sum;
  logic [W-1:0] w_p, w_lane;
  function automatic logic [7:0] sine(input logic [4:0] k);
    logic [4:0] h, q;
    h = k >= 5'd12 ? k - 5'd12 : k;
    q = h > 5'd6 ? 5'd12 - h : h;
    case (q)
      5'd0: sine = 8'd0;
      5'd1: sine = 8'd66;
      5'd2: sine = 8'd128;
      5'd3: sine = 8'd180;
      5'd4: sine = 8'd221;
      5'd5: sine = 8'd246;
      default: sine = 8'd255;
    endcase
  endfunction
  always_comb begin
    w_step = bus.lcStep >= 5'd24 ? bus.lcStep - 5'd24 : bus.lcStep;
    w_sum = 7'(r_step) + 7'(r_ch) * 7'(PHASE_OFS);
    w_idx = 5'(w_sum % 7'd24);
    w_p = r_acc[W+7:8];
    w_lane = r_mag == 8'd0 ? '0 : (w_p < r_min ? r_min : w_p);
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_st <= IDLE;
      r_want <= '0;
      r_min <= '0;
      r_step <= '0;
      r_ch <= '0;
      r_bit <= '0;
      r_mag <= '0;
      r_acc <= '0;
      for (int k = 0; k < NCH; k++) r_sh[k] <= '0;
      r_sgn_sh <= '0;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      r_len <= '0;
      r_sgn <= '0;
      r_sl <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_st)
        IDLE: if (bus.calc_start) begin
          r_want <= bus.m3r_pwmLenWant;
          r_min <= bus.m3r_pwmMinMask;
          r_step <= w_step;
          r_ch <= '0;
          r_busy <= 1'b1;
          r_st <= LOAD;
        end
        LOAD: begin
          r_mag <= sine(w_idx);
          r_acc <= '0;
          r_bit <= '0;
          r_st <= MUL;
        end
        MUL: begin
          if (r_mag[r_bit]) r_acc <= r_acc + ((W+8)'(r_want) << r_bit);
          r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_st <= CLAMP;
        end
        CLAMP: begin
          r_sh[r_ch] <= w_lane;
          r_sgn_sh[r_ch] <= w_idx >= 5'd12;
          if (r_ch == CW'(NCH - 1)) begin
            r_busy <= 1'b0;
            r_st <= DONE;
          end else begin
            r_ch <= r_ch + CW'(1);
            r_st <= LOAD;
          end
        end
        DONE: begin
          // all lanes land together so the PWM side never sees a mixed result
          for (int k = 0; k < NCH; k++) r_len[k*W +: W] <= r_sh[k];
          r_sgn <= r_sgn_sh;
          r_sl <= sine(r_step);
          r_valid <= 1'b1;
          r_st <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
  assign bus.calc_busy = r_busy;
  assign bus.calc_valid = r_valid;
  assign bus.plLen = r_len;
  assign bus.plSign = r_sgn;
  assign bus.slLen = r_sl;
endmodule

// File: tb/tb_motoro3_line_calc_param_seq.sv
// tb_motoro3_line_calc_param_seq: scoreboard bench for the NCH=3 and NCH=1 builds of the line calculator
`timescale 1ns/1ps
module tb_motoro3_line_calc_param_seq;
  typedef struct {logic [35:0] len; logic [2:0] sgn; logic [7:0] sl; int t0; int lat;} exp_t;
  typedef struct {string nm; logic [35:0] a; logic [35:0] e;} dchk_t;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int nv3 = 0;
  int nv1 = 0;
  exp_t q3[$];
  exp_t q1[$];
  dchk_t dq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  motoro3_line_calc_param_seq_if #(.W(12), .NCH(3)) b3();
  motoro3_line_calc_param_seq_if #(.W(12), .NCH(1)) b1();
  motoro3_line_calc_param_seq #(.W(12), .NCH(3), .PHASE_OFS(8)) dut3 (.clk(clk), .nRst(nRst), .bus(b3));
  motoro3_line_calc_param_seq #(.W(12), .NCH(1), .PHASE_OFS(8)) dut1 (.clk(clk), .nRst(nRst), .bus(b1));
  task automatic chk(input string nm, input logic [35:0] a, input logic [35:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, a, a, e, e);
    end
  endtask
  task automatic dchk(input string nm, input logic [35:0] a, input logic [35:0] e);
    dq.push_back('{nm, a, e});
  endtask
  always @(negedge clk) begin
    exp_t e;
    while (dq.size() != 0) begin
      dchk_t d;
      d = dq.pop_front();
      chk(d.nm, d.a, d.e);
    end
    if (b3.calc_valid) begin
      nv3++;
      chk("valid3_expected", 36'(q3.size() != 0), 36'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("plLen3", 36'(b3.plLen), e.len);
        chk("plSign3", 36'(b3.plSign), 36'(e.sgn));
        chk("slLen3", 36'(b3.slLen), 36'(e.sl));
        chk("latency3", 36'(cyc - e.t0), 36'(e.lat));
      end
    end
    if (b1.calc_valid) begin
      nv1++;
      chk("valid1_expected", 36'(q1.size() != 0), 36'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("plLen1", 36'(b1.plLen), e.len);
        chk("plSign1", 36'(b1.plSign), 36'(e.sgn));
        chk("slLen1", 36'(b1.slLen), 36'(e.sl));
        chk("latency1", 36'(cyc - e.t0), 36'(e.lat));
      end
    end
  end
  task automatic go3(input logic [4:0] st, input logic [11:0] wn, input logic [11:0] mn,
                     input logic [35:0] el, input logic [2:0] es, input logic [7:0] esl);
    @(negedge clk);
    b3.lcStep = st;
    b3.m3r_pwmLenWant = wn;
    b3.m3r_pwmMinMask = mn;
    b3.calc_start = 1'b1;
    @(posedge clk);
    #1 b3.calc_start = 1'b0;
    q3.push_back('{el, es, esl, cyc, 31});
    dchk("busy3_after_start", 36'(b3.calc_busy), 36'd1);
  endtask
  task automatic go1(input logic [4:0] st, input logic [11:0] wn, input logic [11:0] mn,
                     input logic [35:0] el, input logic [2:0] es, input logic [7:0] esl);
    @(negedge clk);
    b1.lcStep = st;
    b1.m3r_pwmLenWant = wn;
    b1.m3r_pwmMinMask = mn;
    b1.calc_start = 1'b1;
    @(posedge clk);
    #1 b1.calc_start = 1'b0;
    q1.push_back('{el, es, esl, cyc, 11});
  endtask
  task automatic wait3();
    int n = 0;
    while (q3.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dchk("done3_in_time", 36'(q3.size()), 36'd0);
  endtask
  task automatic wait1();
    int n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dchk("done1_in_time", 36'(q1.size()), 36'd0);
  endtask
  initial begin
    int v0;
    int n;
    b3.calc_start = 1'b0;
    b3.lcStep = '0;
    b3.m3r_pwmLenWant = '0;
    b3.m3r_pwmMinMask = '0;
    b1.calc_start = 1'b0;
    b1.lcStep = '0;
    b1.m3r_pwmLenWant = '0;
    b1.m3r_pwmMinMask = '0;
    repeat (3) @(negedge clk);
    dchk("rst_plLen3", 36'(b3.plLen), 36'd0);
    dchk("rst_plSign3", 36'(b3.plSign), 36'd0);
    dchk("rst_slLen3", 36'(b3.slLen), 36'd0);
    dchk("rst_valid3", 36'(b3.calc_valid), 36'd0);
    dchk("rst_busy3", 36'(b3.calc_busy), 36'd0);
    dchk("rst_plLen1", 36'(b1.plLen), 36'd0);
    nRst = 1'b1;
    go3(5'd0, 12'd1000, 12'd16, {12'd863, 12'd863, 12'd0}, 3'b100, 8'd0);
    wait3();
    go3(5'd1, 12'd40, 12'd16, {12'd38, 12'd28, 12'd16}, 3'b100, 8'd66);
    wait3();
    go3(5'd6, 12'd4095, 12'd0, {12'd2047, 12'd2047, 12'd4079}, 3'b110, 8'd255);
    wait3();
    go3(5'd0, 12'd10, 12'd100, {12'd100, 12'd100, 12'd0}, 3'b100, 8'd0);
    wait3();
    v0 = nv3;
    go3(5'd30, 12'd4095, 12'd0, {12'd2047, 12'd2047, 12'd4079}, 3'b110, 8'd255);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      b3.calc_start = 1'b1;
      b3.lcStep = 5'(i);
      b3.m3r_pwmLenWant = 12'(i * 37);
      b3.m3r_pwmMinMask = 12'd500;
    end
    @(negedge clk);
    b3.calc_start = 1'b0;
    wait3();
    repeat (5) @(negedge clk);
    dchk("t4_single_valid", 36'(nv3 - v0), 36'd1);
    go3(5'd0, 12'd1000, 12'd16, {12'd863, 12'd863, 12'd0}, 3'b100, 8'd0);
    repeat (15) @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    dchk("t5_plLen3", 36'(b3.plLen), 36'd0);
    dchk("t5_plSign3", 36'(b3.plSign), 36'd0);
    dchk("t5_slLen3", 36'(b3.slLen), 36'd0);
    dchk("t5_busy3", 36'(b3.calc_busy), 36'd0);
    q3.delete();
    v0 = nv3;
    @(negedge clk);
    nRst = 1'b1;
    repeat (40) @(negedge clk);
    dchk("t5_no_valid", 36'(nv3 - v0), 36'd0);
    go3(5'd0, 12'd1000, 12'd16, {12'd863, 12'd863, 12'd0}, 3'b100, 8'd0);
    wait3();
    go1(5'd6, 12'd4095, 12'd0, 36'd4079, 3'b000, 8'd255);
    n = 0;
    while (!b1.calc_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    dchk("t6_first_valid", 36'(b1.calc_valid), 36'd1);
    go1(5'd14, 12'd4095, 12'd0, 36'd2047, 3'b001, 8'd128);
    wait1();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
